aux_phy_arbiter: RTL and testbench

AUX_PHY_ARBITER -- requirements
Module: aux_phy_arbiter

---
 rtl/aux_arb_pkg.sv | 34 +++
 rtl/aux_reply_timer.sv | 39 +++
 rtl/aux_phy_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_aux_phy_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_arb_pkg.sv
// Shared types and constants for the AUX PHY arbiter.
package aux_arb_pkg;

  localparam int LEN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_REPLY,
    ST_RX,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    GNT_NAT = 1'b0,
    GNT_I2C = 1'b1
  } grant_e;

  // Round-robin pick: on a tie the requester not granted last time wins.
  function automatic grant_e pick_grant(input logic nat_req,
                                        input logic i2c_req,
                                        input grant_e last_gnt);
    grant_e gnt;
    if (nat_req && i2c_req) begin
      gnt = (last_gnt == GNT_NAT) ? GNT_I2C : GNT_NAT;
    end else if (nat_req) begin
      gnt = GNT_NAT;
    end else begin
      gnt = GNT_I2C;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/aux_reply_timer.sv
// Reply timeout counter: counts enabled cycles, saturates at the limit.
module aux_reply_timer #(
  parameter int TIMEOUT_CYCLES = 400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == LIMIT);

  // Clear has priority; counting stops at the limit so it never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aux_phy_arbiter.sv
// Arbitrates the native and I2C-over-AUX requesters onto one AUX PHY channel.
module aux_phy_arbiter #(
  parameter int TIMEOUT_CYCLES = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nat_req,
  input  logic [3:0] nat_len,
  input  logic [7:0] nat_data,
  input  logic       i2c_req,
  input  logic [3:0] i2c_len,
  input  logic [7:0] i2c_data,
  output logic       nat_rd,
  output logic       i2c_rd,
  output logic [7:0] arb_aux_out,
  output logic       arb_aux_out_vld,
  input  logic [7:0] bdi_aux_in,
  input  logic       bdi_aux_in_vld,
  output logic [7:0] rep_data,
  output logic       nat_rep_vld,
  output logic       i2c_rep_vld,
  output logic       nat_done,
  output logic       i2c_done,
  output logic       nat_timeout,
  output logic       i2c_timeout,
  output logic       busy
);

  import aux_arb_pkg::*;

  arb_state_e       state_q, state_d;
  grant_e           grant_q, grant_d;
  grant_e           last_q, last_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic       nat_rd_q, nat_rd_d;
  logic       i2c_rd_q, i2c_rd_d;
  logic       tx_vld_q, tx_vld_d;
  logic [7:0] rep_data_q, rep_data_d;
  logic       nat_rep_vld_q, nat_rep_vld_d;
  logic       i2c_rep_vld_q, i2c_rep_vld_d;
  logic       nat_done_q, nat_done_d;
  logic       i2c_done_q, i2c_done_d;
  logic       nat_timeout_q, nat_timeout_d;
  logic       i2c_timeout_q, i2c_timeout_d;
  logic       busy_q, busy_d;

  logic [LEN_W-1:0] len_sel;
  logic             last_byte;
  logic             timer_en;
  logic             timer_clr;
  logic             timer_expired;

  assign len_sel   = (grant_q == GNT_NAT) ? nat_len : i2c_len;
  assign last_byte = (cnt_q == len_sel);

  // The timer runs from the last TX cycle through WAIT_REPLY, held at zero otherwise.
  assign timer_en  = ((state_q == ST_TX) && last_byte) || (state_q == ST_WAIT_REPLY);
  assign timer_clr = !timer_en;

  aux_reply_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clr),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // State, grant and byte-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NAT;
      last_q  <= GNT_I2C;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the grant is only decided while leaving IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (nat_req || i2c_req) begin
          grant_d = pick_grant(nat_req, i2c_req, last_q);
          last_d  = grant_d;
          cnt_d   = '0;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (last_byte) begin
          state_d = ST_WAIT_REPLY;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_WAIT_REPLY: begin
        if (bdi_aux_in_vld) begin
          state_d = ST_RX;
        end else if (timer_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_RX: begin
        if (!bdi_aux_in_vld) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every flopped strobe lines up with its state.
  always_comb begin
    tx_vld_d      = (state_d == ST_TX);
    nat_rd_d      = tx_vld_d && (grant_d == GNT_NAT);
    i2c_rd_d      = tx_vld_d && (grant_d == GNT_I2C);
    rep_data_d    = rep_data_q;
    nat_rep_vld_d = 1'b0;
    i2c_rep_vld_d = 1'b0;
    if (bdi_aux_in_vld && ((state_q == ST_WAIT_REPLY) || (state_q == ST_RX))) begin
      rep_data_d    = bdi_aux_in;
      nat_rep_vld_d = (grant_q == GNT_NAT);
      i2c_rep_vld_d = (grant_q == GNT_I2C);
    end
    nat_done_d    = (state_d == ST_DONE) && (grant_q == GNT_NAT);
    i2c_done_d    = (state_d == ST_DONE) && (grant_q == GNT_I2C);
    nat_timeout_d = (state_q == ST_WAIT_REPLY) && !bdi_aux_in_vld && timer_expired &&
                    (grant_q == GNT_NAT);
    i2c_timeout_d = (state_q == ST_WAIT_REPLY) && !bdi_aux_in_vld && timer_expired &&
                    (grant_q == GNT_I2C);
    busy_d        = (state_d != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nat_rd_q      <= 1'b0;
      i2c_rd_q      <= 1'b0;
      tx_vld_q      <= 1'b0;
      rep_data_q    <= '0;
      nat_rep_vld_q <= 1'b0;
      i2c_rep_vld_q <= 1'b0;
      nat_done_q    <= 1'b0;
      i2c_done_q    <= 1'b0;
      nat_timeout_q <= 1'b0;
      i2c_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      nat_rd_q      <= nat_rd_d;
      i2c_rd_q      <= i2c_rd_d;
      tx_vld_q      <= tx_vld_d;
      rep_data_q    <= rep_data_d;
      nat_rep_vld_q <= nat_rep_vld_d;
      i2c_rep_vld_q <= i2c_rep_vld_d;
      nat_done_q    <= nat_done_d;
      i2c_done_q    <= i2c_done_d;
      nat_timeout_q <= nat_timeout_d;
      i2c_timeout_q <= i2c_timeout_d;
      busy_q        <= busy_d;
    end
  end

  // The TX byte is the requester's current byte, selected and gated by flopped
  // grant/valid, so the byte shown always matches the one the pop strobe consumes.
  assign arb_aux_out     = !tx_vld_q ? 8'h00 : ((grant_q == GNT_NAT) ? nat_data : i2c_data);
  assign arb_aux_out_vld = tx_vld_q;
  assign nat_rd          = nat_rd_q;
  assign i2c_rd          = i2c_rd_q;
  assign rep_data        = rep_data_q;
  assign nat_rep_vld     = nat_rep_vld_q;
  assign i2c_rep_vld     = i2c_rep_vld_q;
  assign nat_done        = nat_done_q;
  assign i2c_done        = i2c_done_q;
  assign nat_timeout     = nat_timeout_q;
  assign i2c_timeout     = i2c_timeout_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_aux_phy_arbiter.sv
// Directed bench for aux_phy_arbiter with a queue-based scoreboard.
module tb_aux_phy_arbiter;

  localparam int TB_TIMEOUT = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nat_req = 1'b0;
  logic [3:0] nat_len = 4'd0;
  logic [7:0] nat_data = 8'h00;
  logic       i2c_req = 1'b0;
  logic [3:0] i2c_len = 4'd0;
  logic [7:0] i2c_data = 8'h00;
  logic       nat_rd, i2c_rd;
  logic [7:0] arb_aux_out;
  logic       arb_aux_out_vld;
  logic [7:0] bdi_aux_in = 8'h00;
  logic       bdi_aux_in_vld = 1'b0;
  logic [7:0] rep_data;
  logic       nat_rep_vld, i2c_rep_vld;
  logic       nat_done, i2c_done;
  logic       nat_timeout, i2c_timeout;
  logic       busy;

  aux_phy_arbiter #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .nat_req        (nat_req),
    .nat_len        (nat_len),
    .nat_data       (nat_data),
    .i2c_req        (i2c_req),
    .i2c_len        (i2c_len),
    .i2c_data       (i2c_data),
    .nat_rd         (nat_rd),
    .i2c_rd         (i2c_rd),
    .arb_aux_out    (arb_aux_out),
    .arb_aux_out_vld(arb_aux_out_vld),
    .bdi_aux_in     (bdi_aux_in),
    .bdi_aux_in_vld (bdi_aux_in_vld),
    .rep_data       (rep_data),
    .nat_rep_vld    (nat_rep_vld),
    .i2c_rep_vld    (i2c_rep_vld),
    .nat_done       (nat_done),
    .i2c_done       (i2c_done),
    .nat_timeout    (nat_timeout),
    .i2c_timeout    (i2c_timeout),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       is_nat;
  } exp_byte_t;

  typedef struct packed {
    logic is_timeout;
    logic is_nat;
  } exp_evt_t;

  exp_byte_t tx_q[$];
  exp_byte_t rep_q[$];
  exp_evt_t  evt_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int tx_cnt = 0;
  int evt_cnt = 0;
  int first_vld_cycle = 0;
  int last_vld_cycle = 0;
  int last_evt_cycle = 0;
  logic prev_vld = 1'b0;
  logic [7:0] nat_bytes[16];
  logic [7:0] i2c_bytes[16];
  int nat_idx = 0;
  int i2c_idx = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Scoreboard: every observed strobe pops and compares the oldest expectation.
  task automatic monitor();
    exp_byte_t e;
    exp_evt_t  v;
    if (arb_aux_out_vld) begin
      if (!prev_vld) first_vld_cycle = cycle;
      last_vld_cycle = cycle;
      tx_cnt++;
      check_output("tx_q_nonempty", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) begin
        e = tx_q.pop_front();
        check_output("tx_byte", arb_aux_out, e.data);
        check_output("tx_rd_pair", {nat_rd, i2c_rd}, {e.is_nat, !e.is_nat});
      end
    end else begin
      check_output("rd_without_vld", {nat_rd, i2c_rd}, 0);
    end
    prev_vld = arb_aux_out_vld;
    if (nat_rep_vld || i2c_rep_vld) begin
      check_output("rep_q_nonempty", 32'(rep_q.size() != 0), 1);
      if (rep_q.size() != 0) begin
        e = rep_q.pop_front();
        check_output("rep_data", rep_data, e.data);
        check_output("rep_vld_pair", {nat_rep_vld, i2c_rep_vld}, {e.is_nat, !e.is_nat});
      end
    end
    if (nat_done || i2c_done || nat_timeout || i2c_timeout) begin
      evt_cnt++;
      last_evt_cycle = cycle;
      check_output("evt_q_nonempty", 32'(evt_q.size() != 0), 1);
      if (evt_q.size() != 0) begin
        v = evt_q.pop_front();
        check_output("evt_kind", {nat_done, i2c_done, nat_timeout, i2c_timeout},
                     v.is_timeout ? {2'b00, v.is_nat, !v.is_nat} : {v.is_nat, !v.is_nat, 2'b00});
      end
    end
  endtask

  // One clock: requesters advance on the pop strobe they saw, then outputs are checked.
  task automatic tick();
    logic nr, ir;
    nr = nat_rd;
    ir = i2c_rd;
    @(posedge clk);
    #1;
    cycle++;
    if (nr && nat_idx < 15) begin
      nat_idx++;
      nat_data = nat_bytes[nat_idx];
    end
    if (ir && i2c_idx < 15) begin
      i2c_idx++;
      i2c_data = i2c_bytes[i2c_idx];
    end
    #1;
    monitor();
    if (nat_done || nat_timeout) nat_req = 1'b0;
    if (i2c_done || i2c_timeout) i2c_req = 1'b0;
  endtask

  task automatic push_evt(input logic is_timeout, input logic is_nat);
    exp_evt_t v;
    v.is_timeout = is_timeout;
    v.is_nat     = is_nat;
    evt_q.push_back(v);
  endtask

  // Raise a request and queue the TX bytes it must produce.
  task automatic apply_stimulus(input logic is_nat, input int len);
    exp_byte_t e;
    for (int i = 0; i <= len; i++) begin
      e.data   = is_nat ? nat_bytes[i] : i2c_bytes[i];
      e.is_nat = is_nat;
      tx_q.push_back(e);
    end
    if (is_nat) begin
      nat_len  = 4'(len);
      nat_idx  = 0;
      nat_data = nat_bytes[0];
      nat_req  = 1'b1;
    end else begin
      i2c_len  = 4'(len);
      i2c_idx  = 0;
      i2c_data = i2c_bytes[0];
      i2c_req  = 1'b1;
    end
  endtask

  task automatic wait_tx_end(input int n);
    int   start;
    int   k;
    logic ok;
    start = tx_cnt;
    k = 0;
    ok = 1'b0;
    while (!ok && k < 100) begin
      tick();
      k++;
      ok = ((tx_cnt - start) >= n) && !arb_aux_out_vld;
    end
    check_output("tx_finished", 32'(ok), 1);
    check_output("tx_count", tx_cnt - start, n);
    check_output("tx_burst_len", last_vld_cycle - first_vld_cycle, n - 1);
  endtask

  // Drive an n-byte reply, then the idle cycle that ends it; expect done.
  task automatic serve(input logic is_nat, input int n, input logic [7:0] r0, input logic [7:0] r1);
    exp_byte_t e;
    for (int i = 0; i < n; i++) begin
      bdi_aux_in     = (i == 0) ? r0 : r1;
      bdi_aux_in_vld = 1'b1;
      e.data   = bdi_aux_in;
      e.is_nat = is_nat;
      rep_q.push_back(e);
      tick();
    end
    bdi_aux_in_vld = 1'b0;
    bdi_aux_in     = 8'h00;
    push_evt(1'b0, is_nat);
    tick();
    check_output("rep_all_seen", rep_q.size(), 0);
    check_output("done_seen", evt_q.size(), 0);
    tick();
    check_output("idle_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_tx"}, {arb_aux_out_vld, arb_aux_out, nat_rd, i2c_rd}, 0);
    check_output({tag, "_rep"}, {rep_data, nat_rep_vld, i2c_rep_vld}, 0);
    check_output({tag, "_status"}, {nat_done, i2c_done, nat_timeout, i2c_timeout}, 0);
  endtask

  initial begin
    int t0;
    int k;
    int start;
    int evt_saved;

    // Reset state.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Reply strobes while idle are ignored.
    bdi_aux_in = 8'hEE;
    bdi_aux_in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("idle_bdi_no_rep", {nat_rep_vld, i2c_rep_vld}, 0);
      check_output("idle_bdi_busy", busy, 0);
    end
    bdi_aux_in_vld = 1'b0;
    tick();

    // Two simultaneous pairs: native wins both times.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        nat_bytes[i] = 8'(8'hA0 + i + p * 16);
        i2c_bytes[i] = 8'(8'hB0 + i + p * 16);
      end
      apply_stimulus(1'b1, 1);
      apply_stimulus(1'b0, 2);
      wait_tx_end(2);
      serve(1'b1, 1, 8'(8'h11 + p), 8'h00);
      wait_tx_end(3);
      serve(1'b0, 2, 8'(8'h22 + p), 8'(8'h33 + p));
    end

    // Native four-byte request with a two-byte reply.
    nat_bytes[0] = 8'h90;
    nat_bytes[1] = 8'h00;
    nat_bytes[2] = 8'h01;
    nat_bytes[3] = 8'h00;
    apply_stimulus(1'b1, 3);
    wait_tx_end(4);
    serve(1'b1, 2, 8'h00, 8'hAB);

    // I2C single byte with no reply: timeout.
    i2c_bytes[0] = 8'h55;
    apply_stimulus(1'b0, 0);
    push_evt(1'b1, 1'b0);
    wait_tx_end(1);
    t0 = last_vld_cycle;
    k = 0;
    while (evt_q.size() != 0 && k < TB_TIMEOUT + 20) begin
      tick();
      k++;
    end
    check_output("timeout_seen", evt_q.size(), 0);
    check_output("timeout_cycle", last_evt_cycle - t0, TB_TIMEOUT);
    check_output("timeout_busy", busy, 0);
    tick();
    check_output("idle_after_timeout", busy, 0);

    // Reply arrives in the very cycle the limit is reached: reply wins.
    nat_bytes[0] = 8'hC3;
    apply_stimulus(1'b1, 0);
    wait_tx_end(1);
    t0 = last_vld_cycle;
    k = 0;
    while (cycle < t0 + TB_TIMEOUT - 1 && k < TB_TIMEOUT + 20) begin
      tick();
      k++;
    end
    check_output("limit_cycle_reached", cycle - t0, TB_TIMEOUT - 1);
    check_output("wait_busy_at_limit", busy, 1);
    serve(1'b1, 1, 8'h3C, 8'h00);

    // Sixteen-byte request; request dropped after TX still completes.
    for (int i = 0; i < 16; i++) nat_bytes[i] = 8'(i * 7 + 3);
    apply_stimulus(1'b1, 15);
    wait_tx_end(16);
    nat_req = 1'b0;
    serve(1'b1, 1, 8'h5A, 8'h00);

    // Reset in the third TX cycle abandons the transaction.
    for (int i = 0; i < 16; i++) nat_bytes[i] = 8'(8'h40 + i);
    apply_stimulus(1'b1, 5);
    start = tx_cnt;
    k = 0;
    while ((tx_cnt - start) < 3 && k < 50) begin
      tick();
      k++;
    end
    check_output("third_tx_reached", tx_cnt - start, 3);
    evt_saved = evt_cnt;
    rst_n = 1'b0;
    nat_req = 1'b0;
    tick();
    tx_q.delete();
    check_all_zero("mid_tx_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_output("no_status_after_reset", evt_cnt, evt_saved);
    check_output("idle_after_reset", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
